gauss3x3_filter: RTL and testbench
==================================

Name: gauss3x3_filter

Overview:
- Canny stage 1 smoothing. Sits directly downstream of the three-line buffer and consumes its three vertically aligned row taps plus sync.
- Builds a 3x3 window and applies the 1-2-1 / 2-4-2 / 1-2-1 Gaussian kernel with /16 rounding.
- Emits one smoothed pixel per input pixel, same frame geometry, fixed 4-cycle latency, for the Sobel gradient stage.
- Image borders use edge replication, so the output raster is the same size as the input raster.

Parameters:
- DW, 8, pixel width in bits.
- AW, 10, column counter width; maximum line length is 2^AW pixels.

Ports:
- clk  in  1  pixel clock.
- rst_b  in  1  reset. Synchronous and active-high (asserted = 1); the name follows the codebase convention.
- vvalid  in  1  frame valid from the line buffer.
- hvalid  in  1  line valid; one pixel per cycle while high.
- din  in  3*DW  row taps: [3DW-1:2DW] top (oldest line), [2DW-1:DW] centre, [DW-1:0] bottom (newest line).
- first_row  in  1  qualified with hvalid: the centre row is frame row 0, so the top tap is invalid.
- last_row  in  1  qualified with hvalid: the centre row is the last frame row, so the bottom tap is invalid.
- fsync  out  1  vvalid delayed exactly 4 cycles.
- hsync  out  1  hvalid delayed exactly 4 cycles.
- dout  out  DW  smoothed pixel; valid while hsync = 1.

Behaviour:
- Reset: on any clk edge with rst_b = 1, all pipeline, window, column and delay registers clear. fsync, hsync and dout read 0 from the next cycle. A reset mid-line or mid-frame discards all in-flight pixels; no partial flush.
- Row fix-up, applied before the window:
  - first_row: top tap := centre tap.
  - last_row: bottom tap := centre tap.
  - Both set (one-line frame): both replaced.
- Window stage (S0), three column registers c0/c1/c2, each 3 rows:
  - When hvalid = 1: c0 <= c1, c1 <= c2, c2 <= fixed-up din. The column counter increments and resets to 0 on the hvalid rising edge.
  - Flush cycle, when hvalid = 0 and the previous cycle had hvalid = 1: c0 <= c1, c1 <= c2, c2 holds. This makes the right column a replica for the last pixel.
  - The centre pixel is column k-1 after pixel k is captured. When the centre is column 0, the left column is taken as c1 (replicated).
  - A line of width W therefore yields W centre positions: W-1 from pixels 1..W-1 plus one flush. W = 1 is legal: the flush gives centre 0 with both sides replicated.
  - hvalid must drop for at least 1 cycle between lines. The flush always uses the first blanking cycle.
- S1 (registered): horizontal sums per row, h = L + 2C + R, width DW+2.
- S2 (registered): v = h_top + 2*h_mid + h_bot + 8, width DW+4; dout = v[DW+3:4]. The maximum is 16*(2^DW - 1) + 8, so no overflow or saturation is needed.
- Latency: a pixel present on din in cycle n has its result on dout in cycle n+4.
  - hsync and fsync are shift-register delays of hvalid and vvalid by 4, so their pulse widths equal the input widths.
  - A data-valid tag travels with S0–S2 and must agree with hsync; this is an assertion in the bench.
- The first_row and last_row flags travel with their pixels. Changing them between lines is legal; changing them mid-line is not supported.
- hvalid while vvalid = 0 is processed normally; sync outputs simply mirror the inputs.
- Back-to-back frames with no gap are legal; no state carries over except the pipeline contents.

Test Plan:
- Flat 8x4 frame, all pixels 100, correct first_row/last_row flags -> every dout = 100; hsync exactly 4 cycles after hvalid with 8-cycle pulses; fsync mirrors vvalid delayed 4.
- 5x5 frame of zeros with 255 at (2,2) -> dout 64 at (2,2); 32 at its 4-neighbours; 16 at its diagonals; 0 elsewhere.
- 5x5 frame of zeros with 255 at corner (0,0), replication active -> dout(0,0) = (9*255+8)>>4 = 143; dout(0,1) = (3*255+8)>>4 = 48; dout(1,1) = 16.
- Single-pixel lines (W = 1), value 80, 1-cycle blanking between lines -> each dout = 80; one hsync pulse of width 1 per line.
- Maximum stress: all pixels 255, 2^AW-pixel lines, 1-cycle blanking -> dout = 255 throughout, with no wrap or overflow at the column-counter limit.
- rst_b = 1 for 1 cycle mid-line of a random frame -> hsync, fsync and dout are 0 next cycle; a new frame started afterwards matches the golden model exactly.

Source files
------------

// File: rtl/gauss3x3_filter.sv
// rtl/gauss3x3_filter.sv - 3x3 Gaussian (1-2-1) smoothing with edge replication, fixed 4-cycle latency
module gauss3x3_filter #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            vvalid,
    input  logic            hvalid,
    input  logic [3*DW-1:0] din,
    input  logic            first_row,
    input  logic            last_row,
    output logic            fsync,
    output logic            hsync,
    output logic [DW-1:0]   dout
);
    logic [3*DW-1:0]     c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
    logic [AW-1:0]       col_q, col_d;
    logic                lft_q, lft_d;
    logic [3:0]          hsr_q, vsr_q;
    logic                tag0_q, tag1_q, tag2_q;
    logic [2:0][DW+1:0]  h_q, h_d;
    logic [DW-1:0]       dout_q, dout_d;
    logic [3*DW-1:0]     fix_w, left_w;
    logic [DW+3:0]       v_w;
    logic                flush_w;

    // Rows outside the frame are replaced by the centre row before entering the window.
    assign fix_w   = {first_row ? din[DW+:DW] : din[2*DW+:DW],
                      din[DW+:DW],
                      last_row  ? din[DW+:DW] : din[0+:DW]};
    assign flush_w = !hvalid && hsr_q[0];
    assign left_w  = lft_q ? c1_q : c0_q;

    always_comb begin
        c0_d  = c0_q;
        c1_d  = c1_q;
        c2_d  = c2_q;
        col_d = col_q;
        if (hvalid) begin
            c0_d  = c1_q;
            c1_d  = c2_q;
            c2_d  = fix_w;
            col_d = hsr_q[0] ? col_q + AW'(1) : '0;
        end else if (flush_w) begin
            c0_d = c1_q;
            c1_d = c2_q;
        end
        // Centre lands on column 0 either on pixel 1 or on the flush of a one-pixel line.
        lft_d = hsr_q[0] && (col_q == '0);
    end

    always_comb begin
        h_d = '0;
        for (int r = 0; r < 3; r++) begin
            h_d[r] = {2'b00, left_w[r*DW+:DW]} + {1'b0, c1_q[r*DW+:DW], 1'b0}
                   + {2'b00, c2_q[r*DW+:DW]};
        end
    end

    assign v_w    = {2'b00, h_q[2]} + {1'b0, h_q[1], 1'b0} + {2'b00, h_q[0]} + (DW+4)'(8);
    assign dout_d = DW'(v_w >> 4);

    always_ff @(posedge clk) begin
        if (rst_b) begin
            c0_q   <= '0;
            c1_q   <= '0;
            c2_q   <= '0;
            col_q  <= '0;
            lft_q  <= 1'b0;
            hsr_q  <= '0;
            vsr_q  <= '0;
            tag0_q <= 1'b0;
            tag1_q <= 1'b0;
            tag2_q <= 1'b0;
            h_q    <= '0;
            dout_q <= '0;
        end else begin
            c0_q   <= c0_d;
            c1_q   <= c1_d;
            c2_q   <= c2_d;
            col_q  <= col_d;
            lft_q  <= lft_d;
            hsr_q  <= {hsr_q[2:0], hvalid};
            vsr_q  <= {vsr_q[2:0], vvalid};
            tag0_q <= hsr_q[0];
            tag1_q <= tag0_q;
            tag2_q <= tag1_q;
            h_q    <= h_d;
            dout_q <= dout_d;
        end
    end

    assign hsync = hsr_q[3];
    assign fsync = vsr_q[3];
    assign dout  = tag2_q ? dout_q : '0;
endmodule

// File: tb/tb_gauss3x3_filter.sv
// tb/tb_gauss3x3_filter.sv - self-checking bench for gauss3x3_filter
module tb_gauss3x3_filter;
    localparam int DW   = 8;
    localparam int AW   = 10;
    localparam int MAXW = 1024;
    localparam int MAXH = 8;

    logic            clk = 1'b0;
    logic            rst_b, vvalid, hvalid, first_row, last_row;
    logic [3*DW-1:0] din;
    logic            fsync, hsync;
    logic [DW-1:0]   dout;

    gauss3x3_filter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_b(rst_b), .vvalid(vvalid), .hvalid(hvalid), .din(din),
        .first_row(first_row), .last_row(last_row),
        .fsync(fsync), .hsync(hsync), .dout(dout)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] img [0:MAXH-1][0:MAXW-1];
    int   expq[$];
    bit   hq[$];
    bit   vq[$];
    bit   armed   = 1'b0;
    bit   chk_pix = 1'b0;
    int   out_cnt = 0;
    int   hs_cnt  = 0;
    int   got [0:4095];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int x, input int n);
        return (x < 0) ? 0 : ((x >= n) ? n - 1 : x);
    endfunction

    function automatic int gauss_at(input int r, input int c, input int w, input int h);
        int s = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                s += ((dy == 0) ? 2 : 1) * ((dx == 0) ? 2 : 1)
                     * int'(img[clampi(r + dy, h)][clampi(c + dx, w)]);
        return (s + 8) >> 4;
    endfunction

    function automatic int gv(input int k);
        return got[k % 4096];
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            chk("hsync_delay", int'(hsync), int'(hq.pop_front()));
            chk("fsync_delay", int'(fsync), int'(vq.pop_front()));
            chk("valid_tag", int'(dut.tag2_q), int'(hsync));
            if (hsync) begin
                got[out_cnt % 4096] = int'(dout);
                out_cnt++;
                hs_cnt++;
                if (chk_pix) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dout_extra: got %0d expected no pixel", dout);
                    end else begin
                        chk("dout", int'(dout), expq.pop_front());
                    end
                end
            end
            hq.push_back(hvalid);
            vq.push_back(vvalid);
        end
        if (rst_b) begin
            hq.delete();
            vq.delete();
            repeat (4) begin
                hq.push_back(1'b0);
                vq.push_back(1'b0);
            end
            armed = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic line_px(input int r, input int c, input int w, input int h, input bit push);
        logic [DW-1:0] t, b;
        t = (r > 0)     ? img[clampi(r - 1, h)][c] : DW'($urandom);
        b = (r < h - 1) ? img[clampi(r + 1, h)][c] : DW'($urandom);
        hvalid    = 1'b1;
        first_row = (r == 0);
        last_row  = (r == h - 1);
        din       = {t, img[r][c], b};
        if (push) expq.push_back(gauss_at(r, c, w, h));
        cyc();
    endtask

    task automatic blank();
        hvalid    = 1'b0;
        first_row = 1'b0;
        last_row  = 1'b0;
        din       = 3*DW'($urandom);
        cyc();
    endtask

    task automatic frame(input int w, input int h);
        vvalid = 1'b1;
        blank();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) line_px(r, c, w, h, 1'b1);
            blank();
        end
        vvalid = 1'b0;
        repeat (8) blank();
        chk("drain", expq.size(), 0);
    endtask

    task automatic fill(input int w, input int h, input int val, input bit rnd);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = rnd ? DW'($urandom) : DW'(val);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, hs0;
        rst_b = 1'b1; vvalid = 1'b0; hvalid = 1'b0; first_row = 1'b0; last_row = 1'b0; din = '0;
        repeat (3) cyc();
        rst_b = 1'b0;
        chk("reset_hsync", int'(hsync), 0);
        chk("reset_fsync", int'(fsync), 0);
        chk("reset_dout", int'(dout), 0);
        chk_pix = 1'b1;
        repeat (2) blank();

        fill(8, 4, 100, 1'b0);
        b = out_cnt; hs0 = hs_cnt;
        frame(8, 4);
        chk("flat_first", gv(b), 100);
        chk("flat_last", gv(b + 31), 100);
        chk("flat_hs_cnt", hs_cnt - hs0, 32);

        fill(5, 5, 0, 1'b0);
        img[2][2] = 8'd255;
        chk("model_impulse", gauss_at(2, 2, 5, 5), 64);
        b = out_cnt;
        frame(5, 5);
        chk("imp_centre", gv(b + 12), 64);
        chk("imp_north", gv(b + 7), 32);
        chk("imp_west", gv(b + 11), 32);
        chk("imp_diag", gv(b + 6), 16);
        chk("imp_far", gv(b + 0), 0);

        fill(5, 5, 0, 1'b0);
        img[0][0] = 8'd255;
        chk("model_corner", gauss_at(0, 0, 5, 5), 143);
        b = out_cnt;
        frame(5, 5);
        chk("corner_00", gv(b + 0), 143);
        chk("corner_01", gv(b + 1), 48);
        chk("corner_11", gv(b + 6), 16);

        fill(1, 4, 80, 1'b0);
        b = out_cnt; hs0 = hs_cnt;
        frame(1, 4);
        for (int k = 0; k < 4; k++) chk("w1_px", gv(b + k), 80);
        chk("w1_hs_cnt", hs_cnt - hs0, 4);

        fill(6, 1, 0, 1'b1);
        frame(6, 1);

        fill(MAXW, 3, 255, 1'b0);
        b = out_cnt; hs0 = hs_cnt;
        frame(MAXW, 3);
        chk("max_last", gv(b + 3 * MAXW - 1), 255);
        chk("max_hs_cnt", hs_cnt - hs0, 3 * MAXW);

        fill(6, 5, 0, 1'b1);
        chk_pix = 1'b0;
        vvalid = 1'b1;
        blank();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 6; c++) line_px(r, c, 6, 5, 1'b0);
            blank();
        end
        for (int c = 0; c < 3; c++) line_px(2, c, 6, 5, 1'b0);
        rst_b = 1'b1;
        line_px(2, 3, 6, 5, 1'b0);
        rst_b = 1'b0; hvalid = 1'b0; vvalid = 1'b0;
        chk("midrst_hsync", int'(hsync), 0);
        chk("midrst_fsync", int'(fsync), 0);
        chk("midrst_dout", int'(dout), 0);
        expq.delete();
        chk_pix = 1'b1;
        repeat (2) blank();
        fill(7, 5, 0, 1'b1);
        frame(7, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
